// File: rtl/mips_pc_unit.sv
// Program counter and fetch sequencing with redirects, halt detection and the core active flag.
// Build option MIPS_PC_DELAY_SLOT_EN: when defined, redirects take effect after one delay slot.
module mips_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clk_enable_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        active_o,
  output logic        in_delay_slot_o,
  output logic        slot_violation_o
);

  typedef enum logic [1:0] {ST_RUN, ST_SLOT, ST_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        advance;

  assign advance    = clk_enable_i & ~stall_i & ~reset_i;
  assign seq_pc     = pc_q + 32'd4;
  assign target     = redirect_target_i & 32'hFFFF_FFFC;
  assign pc_o       = pc_q;
  assign pc_plus4_o = seq_pc;

`ifdef MIPS_PC_DELAY_SLOT_EN
  logic [31:0] pending_q, pending_d;
  logic        viol_q, viol_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      viol_q    <= viol_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    viol_d    = viol_q;
    if (advance) begin
      case (state_q)
        ST_RUN: begin
          pc_d = seq_pc;
          // A sequential wrap onto the halt address wins over a redirect in the same cycle.
          if (seq_pc == HALT_ADDR) begin
            state_d = ST_HALT;
          end else if (redirect_valid_i) begin
            pending_d = target;
            state_d   = ST_SLOT;
          end
        end
        ST_SLOT: begin
          pc_d    = pending_q;
          state_d = (pending_q == HALT_ADDR) ? ST_HALT : ST_RUN;
          if (redirect_valid_i) begin
            viol_d = 1'b1;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    active_o         = (state_q != ST_HALT);
    in_delay_slot_o  = (state_q == ST_SLOT);
    slot_violation_o = viol_q;
  end
`else
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (advance) begin
      case (state_q)
        ST_RUN: begin
          pc_d = redirect_valid_i ? target : seq_pc;
          if (pc_d == HALT_ADDR) begin
            state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    active_o         = (state_q != ST_HALT);
    in_delay_slot_o  = 1'b0;
    slot_violation_o = 1'b0;
  end
`endif

endmodule
